// File: rtl/key_pkg.sv
// Shared types and constants for the key counter: debounce states, count
// width and key index assignments.
package key_pkg;

   localparam int unsigned COUNT_W  = 10;
   localparam int unsigned NUM_KEYS = 3;

   // Key indices into KEY[]
   localparam int unsigned INC = 0;
   localparam int unsigned DEC = 1;
   localparam int unsigned CLR = 2;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_e;

   // Bits needed to hold a counter running 0..n-1 (never less than 1)
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_counter_if.sv
// Link between the counter top and one key debouncer: the raw active-low
// key level goes in, a single-cycle press pulse comes out.
interface key_counter_if;

   logic key_n;   // raw, unsynchronized, active-low key level
   logic press;   // one-cycle pulse per accepted press or repeat

   modport master (input key_n, output press);
   modport slave  (output key_n, input press);

endinterface

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, four-state debounce FSM with a
// stability counter, registered press pulse.
// Optional auto-repeat is built only when KEY_COUNTER_AUTOREPEAT_EN is defined.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000,
   parameter bit          REPEAT_EN       = 1'b0
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   key_counter_if.master bus
);

   localparam int unsigned    DW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   deb_state_e    state_q, state_d;
   logic [DW-1:0] stab_q, stab_d;
   logic          press_q, press_d;
   logic          key_low;
   logic          stable_done;
   logic          rep_pulse;

   // Two-flop synchronizer; resets to the released (high) level
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= bus.key_n;
         sync2_q <= sync1_q;
      end
   end

   assign key_low     = ~sync2_q;
   assign stable_done = (stab_q == DB_LAST);

   // State register plus stability counter and press pulse
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= RELEASED;
         stab_q  <= '0;
         press_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stab_q  <= stab_d;
         press_q <= press_d;
      end
   end

   // Next-state: a level is accepted only after an unbroken run of samples
   always_comb begin
      state_d = state_q;
      case (state_q)
         RELEASED: begin
            if (key_low) state_d = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!key_low)         state_d = RELEASED;
            else if (stable_done) state_d = PRESSED;
         end
         PRESSED: begin
            if (!key_low) state_d = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (key_low)          state_d = PRESSED;
            else if (stable_done) state_d = RELEASED;
         end
         default: state_d = RELEASED;
      endcase
   end

   // Outputs: stability counter runs only while waiting in place
   always_comb begin
      stab_d  = '0;
      press_d = 1'b0;
      if ((state_q == PRESS_WAIT || state_q == RELEASE_WAIT) && (state_d == state_q)) begin
         stab_d = stab_q + DW'(1);
      end
      if (state_q == PRESS_WAIT && state_d == PRESSED) begin
         press_d = 1'b1;
      end
      if (rep_pulse) begin
         press_d = 1'b1;
      end
   end

   assign bus.press = press_q;

`ifdef KEY_COUNTER_AUTOREPEAT_EN
   localparam int unsigned   RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned   RW          = cnt_width(RMAX);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rpt_q, rpt_d;
   logic          rpt_arm_q, rpt_arm_d;

   // Repeat timer: zero on every entry to PRESSED, first the delay then the period
   always_comb begin
      rpt_d     = '0;
      rpt_arm_d = 1'b0;
      rep_pulse = 1'b0;
      if (REPEAT_EN && state_q == PRESSED && state_d == PRESSED) begin
         if (rpt_q == (rpt_arm_q ? PERIOD_LAST : DELAY_LAST)) begin
            rep_pulse = 1'b1;
            rpt_arm_d = 1'b1;
         end else begin
            rpt_d     = rpt_q + RW'(1);
            rpt_arm_d = rpt_arm_q;
         end
      end
   end

   // Repeat timer registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rpt_q     <= '0;
         rpt_arm_q <= 1'b0;
      end else begin
         rpt_q     <= rpt_d;
         rpt_arm_q <= rpt_arm_d;
      end
   end
`else
   // Repeat timing has no function in this build
   logic unused_rpt_cfg;
   assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, REPEAT_EN};
   assign rep_pulse      = 1'b0;
`endif

endmodule

// File: rtl/key_counter.sv
// Three debounced pushbuttons driving a 10-bit up/down/clear counter shown
// on LEDR. Same-cycle pulses resolve as clear > increment > decrement.
// Auto-repeat on increment/decrement: define KEY_COUNTER_AUTOREPEAT_EN.
module key_counter
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [COUNT_W-1:0]  LEDR
);

   logic [NUM_KEYS-1:0] press;
   logic [COUNT_W-1:0]  count_q, count_d;

   for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_key
      key_counter_if kif ();

      assign kif.key_n = KEY[g];
      assign press[g]  = kif.press;

      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (g != int'(CLR))
      ) u_deb (
         .clk_i   (CLOCK_50),
         .rst_n_i (RESET_N),
         .bus     (kif.master)
      );
   end

   // Priority resolution; lower-priority pulses in the same cycle are dropped
   always_comb begin
      count_d = count_q;
      if (press[CLR])      count_d = '0;
      else if (press[INC]) count_d = count_q + COUNT_W'(1);
      else if (press[DEC]) count_d = count_q - COUNT_W'(1);
   end

   // Count register
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) count_q <= '0;
      else          count_q <= count_d;
   end

   assign LEDR = count_q;

endmodule

// File: tb/tb_key_counter.sv
// Randomized and directed bench for key_counter with a run-length reference
// model of the keys. Build with KEY_COUNTER_AUTOREPEAT_EN to cover repeat.
module tb_key_counter;

   localparam int DEB  = 4;
   localparam int RDLY = 20;
   localparam int RPER = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] key;
   logic [9:0] ledr;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: per key current level, its run length, accepted state
   bit m_lvl  [3];
   int m_run  [3];
   bit m_prs  [3];
   int m_ent  [3];
   int m_cnt;
   int m_pipe [3];
   int exp_ledr;

   int seg_left [3];
   logic [2:0] kv;

   always #5 clk = ~clk;

   key_counter #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RDLY),
      .REPEAT_PERIOD   (RPER)
   ) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .KEY      (key),
      .LEDR     (ledr)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_lvl[i]  = 1'b1;
         m_run[i]  = 0;
         m_prs[i]  = 1'b0;
         m_ent[i]  = 0;
         m_pipe[i] = 0;
      end
      m_cnt    = 0;
      exp_ledr = 0;
   endtask

   // One clock edge of raw key samples; LEDR follows the model three edges later
   task automatic model_edge(input logic [2:0] k);
      logic [2:0] ev;
`ifdef KEY_COUNTER_AUTOREPEAT_EN
      int since;
`endif
      ev = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (k[i] == m_lvl[i]) m_run[i]++;
         else begin
            m_lvl[i] = k[i];
            m_run[i] = 1;
         end
         if (!m_prs[i]) begin
            if (!m_lvl[i] && m_run[i] == DEB + 1) begin
               m_prs[i] = 1'b1;
               m_ent[i] = m_run[i];
               ev[i]    = 1'b1;
            end
         end else if (m_lvl[i]) begin
            if (m_run[i] == DEB + 1) m_prs[i] = 1'b0;
         end else begin
            if (m_run[i] == 1) m_ent[i] = 1;
`ifdef KEY_COUNTER_AUTOREPEAT_EN
            since = m_run[i] - m_ent[i];
            if (i != 2 && since >= RDLY && (since - RDLY) % RPER == 0) ev[i] = 1'b1;
`endif
         end
      end
      if (ev[2])      m_cnt = 0;
      else if (ev[0]) m_cnt = (m_cnt + 1) % 1024;
      else if (ev[1]) m_cnt = (m_cnt + 1023) % 1024;
      exp_ledr  = m_pipe[0];
      m_pipe[0] = m_pipe[1];
      m_pipe[1] = m_pipe[2];
      m_pipe[2] = m_cnt;
   endtask

   // Drive at the falling edge, sample at the next falling edge
   task automatic tick(input logic [2:0] k, input string tag);
      key = k;
      @(posedge clk);
      model_edge(k);
      @(negedge clk);
      check(tag, int'(ledr), exp_ledr);
   endtask

   task automatic press(input logic [2:0] k);
      repeat (DEB + 2) tick(k, "press");
      repeat (DEB + 2) tick(3'b111, "release");
   endtask

   // Asynchronous reset pulse, called at a falling edge; keys left as they are
   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #3;
      check("rst_async", int'(ledr), 0);
      @(negedge clk);
      check("rst_hold", int'(ledr), 0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      key   = 3'b111;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_ledr", int'(ledr), 0);
      rst_n = 1'b1;
      repeat (4) tick(3'b111, "idle");

      // Single clean increment press
      for (int i = 0; i < 10; i++) begin
         tick(3'b110, "press1");
         if (i == 6) check("press1_edge6", int'(ledr), 0);
         if (i == 7) check("press1_edge7", int'(ledr), 1);
      end
      repeat (10) tick(3'b111, "press1_rel");
      check("press1_final", int'(ledr), 1);

      // Bounce shorter than the debounce window
      do_reset();
      for (int i = 0; i < 40; i++) tick(((i / 2) % 2 == 0) ? 3'b110 : 3'b111, "glitch");
      repeat (8) tick(3'b111, "glitch_idle");
      check("glitch_final", int'(ledr), 0);

      // Wrap both ways
      do_reset();
      for (int n = 0; n < 1023; n++) press(3'b110);
      check("preset_1023", int'(ledr), 1023);
      press(3'b110);
      check("wrap_up", int'(ledr), 0);
      press(3'b101);
      check("wrap_down", int'(ledr), 1023);

      // Same-cycle priority
      do_reset();
      repeat (5) press(3'b110);
      check("prio_preset", int'(ledr), 5);
      press(3'b010);
      check("prio_clr_inc", int'(ledr), 0);
      press(3'b100);
      check("prio_inc_dec", int'(ledr), 1);

      // Reset in the middle of a press debounce, key still held
      do_reset();
      repeat (5) tick(3'b110, "mid_press");
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick(3'b110, "redebounce");
         if (i == 6) check("redeb_edge6", int'(ledr), 0);
         if (i == 7) check("redeb_edge7", int'(ledr), 1);
      end
      repeat (8) tick(3'b111, "redeb_rel");
      check("redeb_final", int'(ledr), 1);

      // Long hold: single pulse, or repeats when auto-repeat is built
      do_reset();
      repeat (DEB + 1 + 50) tick(3'b110, "hold");
      repeat (10) tick(3'b111, "hold_rel");
`ifdef KEY_COUNTER_AUTOREPEAT_EN
      check("hold_repeat", int'(ledr), 5);
`else
      check("hold_single", int'(ledr), 1);
`endif

      // Random segments of random level on all keys
      do_reset();
      for (int i = 0; i < 3; i++) seg_left[i] = 0;
      kv = 3'b111;
      for (int t = 0; t < 1500; t++) begin
         for (int i = 0; i < 3; i++) begin
            if (seg_left[i] == 0) begin
               kv[i]       = 1'($urandom_range(0, 1));
               seg_left[i] = int'($urandom_range(1, 14));
            end
            seg_left[i]--;
         end
         tick(kv, "random");
      end
      repeat (12) tick(3'b111, "random_idle");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/key_counter.md
KEY_COUNTER -- requirements
Module: key_counter

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples needed to accept a key level (20 ms at 50 MHz).
REQ-002 SHALL have parameter: REPEAT_DELAY, 25000000, cycles a key must be held before the first auto-repeat (500 ms).
REQ-003 SHALL have parameter: REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats (100 ms).
REQ-004 SHALL have port: CLOCK_50  input  1  the single 50 MHz clock; all state on its rising edge.
REQ-005 SHALL have port: RESET_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: KEY  input  3  raw, unsynchronized, active-low pushbuttons: KEY[0] increment, KEY[1] decrement, KEY[2] clear.
REQ-007 SHALL have port: LEDR  output  10  current count, registered.

Function
REQ-008 Each KEY bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-009 Each key SHALL have its own debounce FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-010 RELEASED -> PRESS_WAIT SHALL occur on a synchronized low sample, with the stability counter cleared.
REQ-011 PRESS_WAIT -> RELEASED SHALL occur on any high sample; PRESS_WAIT -> PRESSED SHALL occur after DEBOUNCE_CYCLES consecutive low samples.
REQ-012 PRESSED -> RELEASE_WAIT SHALL occur on a high sample; RELEASE_WAIT -> PRESSED on a low sample; RELEASE_WAIT -> RELEASED after DEBOUNCE_CYCLES consecutive high samples.
REQ-013 The PRESS_WAIT -> PRESSED transition SHALL emit exactly one single-cycle press pulse per accepted press.
REQ-014 A press pulse SHALL appear 2+DEBOUNCE_CYCLES edges after the edge that first samples the raw low level, and LEDR SHALL update on the following edge.
REQ-015 An increment SHALL add 1 modulo 1024, wrapping 1023 -> 0.
REQ-016 A decrement SHALL subtract 1 modulo 1024, wrapping 0 -> 1023.
REQ-017 A clear SHALL set the count to 0.
REQ-018 Pulses in the same cycle SHALL be resolved by priority clear > increment > decrement, and the lower-priority pulses SHALL be discarded.
REQ-019 Glitches shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no count change.

Reset
REQ-020 RESET_N low SHALL asynchronously force synchronizers to 1 (released), all FSMs to RELEASED, all counters to 0 and LEDR to 0.
REQ-021 Reset deassertion while a key is held SHALL be treated as a new press, debounced from zero.
REQ-022 Asserting reset mid-debounce or mid-repeat SHALL abandon that operation and emit no pulse.

Configuration
REQ-023 Macro KEY_COUNTER_AUTOREPEAT_EN defined: a key in PRESSED SHALL emit additional press pulses, for KEY[0] and KEY[1] only, after REPEAT_DELAY cycles in PRESSED and then every REPEAT_PERIOD cycles.
REQ-024 With KEY_COUNTER_AUTOREPEAT_EN defined, the repeat timer SHALL restart on each entry to PRESSED, so a RELEASE_WAIT bounce restarts the delay.
REQ-025 Macro KEY_COUNTER_AUTOREPEAT_EN undefined: exactly one pulse per press, and no repeat timer logic SHALL be synthesized.

Structure
REQ-026 A shared package key_pkg SHALL hold the debounce state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT), the count width constant 10 and the key index constants INC=0, DEC=1, CLR=2.
REQ-027 The design SHALL have one sub-module, key_debounce (synchronizer, FSM, stability counter, press pulse, optional repeat), instantiated 3 times.
REQ-028 key_counter SHALL hold only the priority resolution and the count register.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-029 Bench SHALL cover: reset, then hold KEY[0] low 10 cycles and release clean -> one pulse at edge 6 after the first low sample, LEDR=1 at edge 7, no further change.
REQ-030 Bench SHALL cover: KEY[0] toggling low/high every 2 cycles for 40 cycles -> LEDR stays 0.
REQ-031 Bench SHALL cover: count preset to 1023 via 1023 presses, one more KEY[0] press -> LEDR=0; then one KEY[1] press -> LEDR=1023.
REQ-032 Bench SHALL cover: KEY[0] and KEY[2] pressed in the same cycle with LEDR=5 -> LEDR=0; then KEY[0] and KEY[1] pressed in the same cycle -> LEDR=1.
REQ-033 Bench SHALL cover: RESET_N pulsed low at cycle 3 of a PRESS_WAIT -> LEDR=0, no pulse, and re-debounce from zero while the key is still held -> LEDR=1.
REQ-034 Bench SHALL cover, with KEY_COUNTER_AUTOREPEAT_EN defined: KEY[0] held 50 cycles after acceptance -> pulses at acceptance, +20, +28, +36, +44, giving LEDR=5.
